// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: shared select width, controller states and tap helper for the clock divider.
package clkdiv_pkg;
  localparam int SEL_W = 3;
  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;
  function automatic int tap_idx(input int cnt_w, input logic [SEL_W-1:0] sel);
    return cnt_w - 1 - int'(sel);
  endfunction
endpackage

// File: rtl/clkdiv_ctrl_rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant; the pointer moves past the winner on accept.
module rr_arbiter #(
  parameter int NREQ = 2,
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic [NREQ-1:0] req_i,
  input  logic            accept_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [PW-1:0]   idx_o
);
  logic [PW-1:0] r_ptr;
  logic          w_found;
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    w_found = 1'b0;
    // First pass covers requesters at or above the pointer, second pass wraps around.
    for (int j = 0; j < NREQ; j++) begin
      if (!w_found && j >= int'(r_ptr) && req_i[j]) begin
        w_found  = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = PW'(j);
      end
    end
    for (int j = 0; j < NREQ; j++) begin
      if (!w_found && j < int'(r_ptr) && req_i[j]) begin
        w_found  = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = PW'(j);
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (!rstn_i) r_ptr <= '0;
    else if (accept_i && w_found) r_ptr <= (idx_o == PW'(NREQ - 1)) ? '0 : idx_o + PW'(1);
  end
endmodule

// File: rtl/clkdiv_ctrl.sv
// clkdiv_ctrl: power-of-two clock divider whose tap select changes only at divided-period boundaries.
module clkdiv_ctrl
  import clkdiv_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int CNT_W   = 16,
  parameter int RST_SEL = 0
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic [NREQ-1:0]       req_i,
  input  logic [SEL_W*NREQ-1:0] sel_req_i,
  output logic [NREQ-1:0]       gnt_o,
  output logic [NREQ-1:0]       ack_o,
  output logic [SEL_W-1:0]      sel_o,
  output logic                  dclk_o,
  output logic                  tick_o,
  output logic                  busy_o
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  function automatic logic [CNT_W-1:0] tap_bit(input logic [SEL_W-1:0] s);
    return CNT_W'(1) << tap_idx(CNT_W, s);
  endfunction
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [SEL_W-1:0] r_pend;
  logic [NREQ-1:0]  w_gnt;
  logic [PW-1:0]    w_idx;
  logic [SEL_W-1:0] w_sel_req;
  logic [SEL_W-1:0] w_sel_nxt;
  logic [CNT_W-1:0] w_mask;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_bnd;
  logic             w_switch;
  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk_i    (clk_i),
    .rstn_i   (rstn_i),
    .req_i    (req_i),
    .accept_i (r_state == IDLE),
    .gnt_o    (w_gnt),
    .idx_o    (w_idx)
  );
  always_comb begin
    w_sel_req = '0;
    for (int j = 0; j < NREQ; j++) w_sel_req = (w_idx == PW'(j)) ? sel_req_i[SEL_W*j +: SEL_W] : w_sel_req;
  end
  // Mask of cnt[tap:0]; the shift overflows to zero at sel 0, giving all ones after the subtract.
  assign w_mask    = (tap_bit(sel_o) << 1) - CNT_W'(1);
  assign w_bnd     = (r_cnt & w_mask) == w_mask;
  assign w_switch  = (r_state == WAIT) && (r_pend != sel_o) && w_bnd;
  assign w_sel_nxt = w_switch ? r_pend : sel_o;
  assign w_cnt_nxt = w_switch ? '0 : r_cnt + CNT_W'(1);
  assign busy_o    = r_state != IDLE;
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_pend  <= '0;
      sel_o   <= SEL_W'(RST_SEL);
      dclk_o  <= 1'b0;
      tick_o  <= 1'b0;
      gnt_o   <= '0;
      ack_o   <= '0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      sel_o  <= w_sel_nxt;
      dclk_o <= |(w_cnt_nxt & tap_bit(w_sel_nxt));
      tick_o <= w_bnd;
      ack_o  <= '0;
      case (r_state)
        IDLE: if (|req_i) begin
          r_pend  <= w_sel_req;
          gnt_o   <= w_gnt;
          r_state <= WAIT;
        end
        WAIT: if (r_pend == sel_o || w_bnd) begin
          ack_o   <= gnt_o;
          gnt_o   <= '0;
          r_state <= ACK;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_clkdiv_ctrl.sv
// tb_clkdiv_ctrl: randomized self-checking bench against a period-arithmetic model of the divider.
module tb_clkdiv_ctrl;
  localparam int NREQ = 2, CNT_W = 8, RST_SEL = 7;
  logic       clk = 1'b0, rstn = 1'b0;
  logic [1:0] req = '0;
  logic [5:0] sel_req = '0;
  logic [1:0] gnt, ack;
  logic [2:0] sel;
  logic       dclk, tick, busy;
  int total = 0, bad = 0;
  int m_cnt = 0, m_rr = 0, m_st = 0;
  logic [2:0] m_sel = 3'(RST_SEL), m_psel = '0;
  logic [1:0] m_gnt = '0, m_ack = '0;
  logic       m_dclk = 1'b0, m_tick = 1'b0;
  wire [9:0] obs   = {gnt, ack, sel, dclk, tick, busy};
  wire [9:0] exp_v = {m_gnt, m_ack, m_sel, m_dclk, m_tick, m_st != 0};

  clkdiv_ctrl #(.NREQ(NREQ), .CNT_W(CNT_W), .RST_SEL(RST_SEL)) dut (
    .clk_i(clk), .rstn_i(rstn), .req_i(req), .sel_req_i(sel_req),
    .gnt_o(gnt), .ack_o(ack), .sel_o(sel), .dclk_o(dclk), .tick_o(tick), .busy_o(busy)
  );

  always #5 clk = ~clk;

  // Reference: divided period is 2^(CNT_W-sel); state 0 idle, 1 waiting, 2 acking.
  always @(posedge clk) begin
    int per, w;
    bit bnd, sw, found;
    if (!rstn) begin
      m_cnt = 0; m_sel = 3'(RST_SEL); m_st = 0; m_rr = 0;
      m_gnt = '0; m_ack = '0; m_dclk = 1'b0; m_tick = 1'b0;
    end else begin
      per = 1 << (CNT_W - int'(m_sel));
      bnd = (m_cnt % per) == per - 1;
      m_tick = bnd;
      m_ack = '0;
      sw = 0;
      if (m_st == 0) begin
        found = 0; w = 0;
        for (int k = 0; k < NREQ; k++)
          if (!found && req[(m_rr + k) % NREQ]) begin found = 1; w = (m_rr + k) % NREQ; end
        if (found) begin
          m_psel = sel_req[3*w +: 3];
          m_gnt = 2'(1 << w);
          m_rr = (w + 1) % NREQ;
          m_st = 1;
        end
      end else if (m_st == 1) begin
        if (m_psel == m_sel || bnd) begin
          sw = m_psel != m_sel;
          if (sw) m_sel = m_psel;
          m_ack = m_gnt;
          m_gnt = '0;
          m_st = 2;
        end
      end else m_st = 0;
      m_cnt = sw ? 0 : (m_cnt + 1) % (1 << CNT_W);
      per = 1 << (CNT_W - int'(m_sel));
      m_dclk = (m_cnt % per) >= per / 2;
    end
  end

  task automatic test_reset();
    rstn = 1'b0; req = '0;
    repeat (3) begin
      @(negedge clk); total++;
      if (obs !== {2'b00, 2'b00, 3'd7, 3'b000}) begin bad++; $display("FAIL reset: got %b want %b", obs, {2'b00, 2'b00, 3'd7, 3'b000}); end
    end
    rstn = 1'b1;
    repeat (12) begin
      @(negedge clk); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL reset_run: got %b want %b", obs, exp_v); end
    end
  endtask

  task automatic test_single();
    sel_req[2:0] = 3'd5; req = 2'b01;
    for (int n = 0; n < 64 && (m_st != 0 || req != 0); n++) begin
      @(negedge clk); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL single: got %b want %b", obs, exp_v); end
      req &= ~m_ack;
    end
    total++;
    if (m_st != 0 || req != 0) begin bad++; $display("FAIL single_timeout: req %b want 00", req); end
    repeat (24) begin
      @(negedge clk); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL single_period: got %b want %b", obs, exp_v); end
    end
  endtask

  task automatic test_contention();
    repeat (2) begin
      sel_req = {3'd6, 3'd4}; req = 2'b11;
      for (int n = 0; n < 800 && (m_st != 0 || req != 0); n++) begin
        @(negedge clk); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL contention: got %b want %b", obs, exp_v); end
        req &= ~m_ack;
      end
      total++;
      if (m_st != 0 || req != 0) begin bad++; $display("FAIL contention_timeout: req %b want 00", req); end
    end
  endtask

  task automatic test_noop();
    sel_req[5:3] = m_sel; req = 2'b10;
    for (int n = 0; n < 16 && (m_st != 0 || req != 0); n++) begin
      @(negedge clk); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL noop: got %b want %b", obs, exp_v); end
      req &= ~m_ack;
    end
    total++;
    if (m_st != 0 || req != 0) begin bad++; $display("FAIL noop_timeout: req %b want 00", req); end
  endtask

  task automatic test_slow_fast();
    for (int p = 0; p < 2; p++) begin
      sel_req = (p == 0) ? 6'o00 : 6'o07; req = (p == 0) ? 2'b10 : 2'b01;
      for (int n = 0; n < 600 && (m_st != 0 || req != 0); n++) begin
        @(negedge clk); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL slow_fast: got %b want %b", obs, exp_v); end
        req &= ~m_ack;
      end
      total++;
      if (m_st != 0 || req != 0) begin bad++; $display("FAIL slow_fast_timeout: req %b want 00", req); end
      repeat ($urandom_range(10, 200)) begin
        @(negedge clk); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL slow_fast_idle: got %b want %b", obs, exp_v); end
      end
    end
  endtask

  task automatic test_reset_wait();
    sel_req = 6'o00; req = 2'b01;
    for (int n = 0; n < 16 && (m_st != 0 || req != 0); n++) begin
      @(negedge clk); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL rst_wait_pre: got %b want %b", obs, exp_v); end
      req &= ~m_ack;
    end
    sel_req = 6'o03; req = 2'b01;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL rst_wait_gnt: got %b want %b", obs, exp_v); end
    end
    total++;
    if (gnt !== 2'b01) begin bad++; $display("FAIL rst_wait_held: gnt %b want 01", gnt); end
    rstn = 1'b0;
    @(negedge clk); total++;
    if (obs !== {2'b00, 2'b00, 3'd7, 3'b000}) begin bad++; $display("FAIL rst_wait_drop: got %b want %b", obs, {2'b00, 2'b00, 3'd7, 3'b000}); end
    rstn = 1'b1;
    for (int n = 0; n < 64 && (m_st != 0 || req != 0); n++) begin
      @(negedge clk); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL rst_wait_regrant: got %b want %b", obs, exp_v); end
      req &= ~m_ack;
    end
    total++;
    if (m_st != 0 || req != 0 || sel !== 3'd3) begin bad++; $display("FAIL rst_wait_done: sel %0d want 3", sel); end
  endtask

  task automatic test_random();
    repeat (25) begin
      sel_req = 6'($urandom); req = 2'($urandom_range(1, 3));
      for (int n = 0; n < 1200 && (m_st != 0 || req != 0); n++) begin
        @(negedge clk); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL random: got %b want %b", obs, exp_v); end
        req &= ~m_ack;
        if (m_gnt != 0 && $urandom_range(0, 1) == 1) sel_req = 6'($urandom);
      end
      total++;
      if (m_st != 0 || req != 0) begin bad++; $display("FAIL random_timeout: req %b want 00", req); end
      repeat ($urandom_range(0, 5)) begin
        @(negedge clk); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL random_idle: got %b want %b", obs, exp_v); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_noop();
    test_slow_fast();
    test_reset_wait();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
